// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the byte-stream program loader.
//   loader_state_t : FSM state encoding for the loader top
//   err_code_t     : failure reason reported on ERR_CODE
//   MAX_WORDS      : largest word count a frame may carry (memory depth)
//   csum_add       : modulo-256 running checksum step
//   pad_ok         : true when the high bits of a B2 byte are all zero
package prog_loader_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CNT_LO = 4'd1,
    CNT_HI = 4'd2,
    B0     = 4'd3,
    B1     = 4'd4,
    B2     = 4'd5,
    WRITE  = 4'd6,
    CHK    = 4'd7,
    ERROR  = 4'd8
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_TIMEOUT = 2'b00,
    ERR_COUNT   = 2'b01,
    ERR_PAD     = 2'b10,
    ERR_CSUM    = 2'b11
  } err_code_t;

  localparam int MAX_WORDS = 1024;
  localparam int CNT_W     = 11;

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

  function automatic logic pad_ok(input logic [7:0] b2);
    return (b2[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// Inter-byte timeout counter for the program loader.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : reload the counter (byte accepted / frame start)
//   i_en           : count down (FSM is inside a frame and waiting for a byte)
//   o_expire       : high for the cycle in which TIMEOUT_CYC cycles have
//                    elapsed since the last load without a new load
module loader_timer #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] r_cnt;

  // Down-counter: reload on accept, decrement while enabled, park at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RELOAD;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (i_en && (r_cnt != {TW{1'b0}})) begin
      r_cnt <= r_cnt - TW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // A load in the expiry cycle means a byte arrived in time, so it masks expiry.
  assign o_expire = i_en & ~i_load & (r_cnt == {TW{1'b0}});

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses SYNC, CNT_LO, CNT_HI, N x {B0,B1,B2}, CHK frames
// from a byte stream and writes 18-bit words into the instruction memory.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_rx_data, i_rx_valid : incoming byte; o_rx_ready completes the handshake
//   o_we, o_waddr, o_wdata: instruction memory write port (1-cycle WE pulse)
//   o_cpu_hold            : keeps the CPU in reset during/after a failed load
//   o_done / o_err        : sticky result of the last frame
//   o_err_code            : 00 timeout, 01 bad count, 10 bad pad, 11 checksum
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          DATA_W      = 18,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  loader_state_t     r_state, w_next;
  logic              r_rx_ready, r_we, r_cpu_hold, r_done, r_err;
  err_code_t         r_err_code, w_fault_code;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_sum, r_cnt_lo, r_b0, r_b1;
  logic [CNT_W-1:0]  r_cnt, r_idx;
  logic              w_accept, w_expire, w_in_frame, w_fault;
  logic [7:0]        w_sum_next;
  logic [CNT_W-1:0]  w_cnt_full;

  assign w_accept   = i_rx_valid & r_rx_ready;
  assign w_sum_next = csum_add(r_sum, i_rx_data);
  assign w_cnt_full = {i_rx_data[2:0], r_cnt_lo};
  assign w_in_frame = r_state inside {CNT_LO, CNT_HI, B0, B1, B2, CHK};

  loader_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_accept),
    .i_en     (w_in_frame),
    .o_expire (w_expire)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; an accepted byte always takes priority over expiry.
  always_comb begin
    w_next       = r_state;
    w_fault      = 1'b0;
    w_fault_code = ERR_TIMEOUT;
    case (r_state)
      IDLE: begin
        if (w_accept && (i_rx_data == SYNC_BYTE)) w_next = CNT_LO;
        else                                      w_next = IDLE;
      end
      CNT_LO: begin
        if (w_accept)      w_next = CNT_HI;
        else if (w_expire) w_fault = 1'b1;
        else               w_next = CNT_LO;
      end
      CNT_HI: begin
        if (w_accept) begin
          if ((i_rx_data[7:3] != 5'd0) || (w_cnt_full == 11'd0) ||
              (w_cnt_full > 11'(MAX_WORDS))) begin
            w_fault      = 1'b1;
            w_fault_code = ERR_COUNT;
          end else begin
            w_next = B0;
          end
        end else if (w_expire) w_fault = 1'b1;
        else                   w_next = CNT_HI;
      end
      B0: begin
        if (w_accept)      w_next = B1;
        else if (w_expire) w_fault = 1'b1;
        else               w_next = B0;
      end
      B1: begin
        if (w_accept)      w_next = B2;
        else if (w_expire) w_fault = 1'b1;
        else               w_next = B1;
      end
      B2: begin
        if (w_accept) begin
          if (pad_ok(i_rx_data)) begin
            w_next = WRITE;
          end else begin
            w_fault      = 1'b1;
            w_fault_code = ERR_PAD;
          end
        end else if (w_expire) w_fault = 1'b1;
        else                   w_next = B2;
      end
      WRITE: begin
        // idx has not been incremented yet, so compare against idx+1.
        if ((r_idx + 11'd1) == r_cnt) w_next = CHK;
        else                          w_next = B0;
      end
      CHK: begin
        if (w_accept) begin
          if (w_sum_next == 8'h00) begin
            w_next = IDLE;
          end else begin
            w_fault      = 1'b1;
            w_fault_code = ERR_CSUM;
          end
        end else if (w_expire) w_fault = 1'b1;
        else                   w_next = CHK;
      end
      ERROR:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_fault) w_next = ERROR;
    else         w_next = w_next;
  end

  // Datapath: byte capture, word assembly, index/count, checksum and status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_ready <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= {ADDR_W{1'b0}};
      r_wdata    <= {DATA_W{1'b0}};
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_TIMEOUT;
      r_sum      <= 8'h00;
      r_cnt_lo   <= 8'h00;
      r_b0       <= 8'h00;
      r_b1       <= 8'h00;
      r_cnt      <= 11'd0;
      r_idx      <= 11'd0;
    end else begin
      r_rx_ready <= !(w_next inside {WRITE, ERROR});
      r_we       <= (w_next == WRITE);
      if (w_accept) begin
        r_sum <= w_sum_next;
        case (r_state)
          IDLE: begin
            if (i_rx_data == SYNC_BYTE) begin
              r_done     <= 1'b0;
              r_err      <= 1'b0;
              r_err_code <= ERR_TIMEOUT;
              r_cpu_hold <= 1'b1;
              r_sum      <= 8'h00;
              r_idx      <= 11'd0;
            end
          end
          CNT_LO: r_cnt_lo <= i_rx_data;
          CNT_HI: r_cnt    <= w_cnt_full;
          B0:     r_b0     <= i_rx_data;
          B1:     r_b1     <= i_rx_data;
          B2: begin
            r_waddr <= r_idx[ADDR_W-1:0];
            r_wdata <= DATA_W'({i_rx_data[1:0], r_b1, r_b0});
          end
          CHK: begin
            if (w_sum_next == 8'h00) begin
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      if (r_state == WRITE) r_idx <= r_idx + 11'd1;
      if (w_fault) begin
        r_err      <= 1'b1;
        r_err_code <= w_fault_code;
      end
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_we       = r_we;
  assign o_waddr    = r_waddr;
  assign o_wdata    = r_wdata;
  assign o_cpu_hold = r_cpu_hold;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule
